// File: rtl/axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_reg_slave
//
// AXI4-Lite responder that terminates one AXI4-Lite channel set in a bank of
// REG_COUNT read/write registers, each 8*N bits wide. The AW and W channels
// are accepted independently, in either order or in the same cycle. Each
// write and each read receives one single-beat B or R response. The register
// contents and a per-register commit pulse are exported to local hardware.
//
// Ports
//   aclk, aresetn          clock (rising edge) and asynchronous active-low reset
//   awaddr/awvalid/awready write address channel
//   wdata/wstrb/wvalid/wready
//                          write data channel (wstrb ignored when USE_STRB == 0)
//   bresp/bvalid/bready    write response channel (OKAY / SLVERR)
//   araddr/arvalid/arready read address channel
//   rdata/rresp/rvalid/rready
//                          read data channel (OKAY / SLVERR; rdata = 0 on error)
//   reg_q                  flattened register bank; register i at [i*8*N +: 8*N]
//   wr_pulse               one-cycle pulse for register i, in the cycle after
//                          its commit (the cycle in which bvalid rises)
// ---------------------------------------------------------------------------
module axi4_lite_reg_slave #(
   parameter int A         = 12,
   parameter int N         = 4,
   parameter int REG_COUNT = 8,
   parameter bit USE_STRB  = 1'b1
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   // write address channel
   input  logic [A-1:0]                 awaddr,
   input  logic                         awvalid,
   output logic                         awready,
   // write data channel
   input  logic [8*N-1:0]               wdata,
   input  logic [N-1:0]                 wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   // write response channel
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   // read address channel
   input  logic [A-1:0]                 araddr,
   input  logic                         arvalid,
   output logic                         arready,
   // read data channel
   output logic [8*N-1:0]               rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   // local hardware side
   output logic [REG_COUNT*8*N-1:0]     reg_q,
   output logic [REG_COUNT-1:0]         wr_pulse
);

   localparam int DW = 8 * N;
   localparam int BO = $clog2(N);          // byte-offset bits, ignored by decode
   localparam int IW = $clog2(REG_COUNT);  // register index bits
   localparam int HI = BO + IW;            // first address bit that must be zero

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // write holding registers
   logic           aw_full;
   logic [A-1:0]   aw_addr;
   logic           w_full;
   logic [DW-1:0]  w_data;
   logic [N-1:0]   w_strb;

   // register bank
   logic [DW-1:0]  regs [REG_COUNT];

   // handshake and commit qualifiers
   logic           aw_hs;
   logic           w_hs;
   logic           ar_hs;
   logic           b_hs;
   logic           r_hs;
   logic           commit;
   logic           commit_ok;
   logic [IW-1:0]  commit_idx;

   // -------------------------------------------------------------------------
   // Address decode helpers
   // -------------------------------------------------------------------------
   function automatic logic [IW-1:0] reg_index(input logic [A-1:0] addr);
      return addr[HI-1:BO];
   endfunction

   // Any set bit above the index field is outside the register window.
   function automatic logic addr_ok(input logic [A-1:0] addr);
      return (addr >> HI) == '0;
   endfunction

   // Byte-lane merge of new data into the old register value.
   function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                 input logic [DW-1:0] new_val,
                                                 input logic [N-1:0]  strb);
      logic [DW-1:0] res;
      res = old_val;
      for (int k = 0; k < N; k++) begin
         if (strb[k] || !USE_STRB) begin
            res[8*k +: 8] = new_val[8*k +: 8];
         end
      end
      return res;
   endfunction

   // -------------------------------------------------------------------------
   // Readies come only from registered state, never from same-cycle valids.
   // While a B response is outstanding neither AW nor W is accepted, so at
   // most one write is in flight.
   // -------------------------------------------------------------------------
   assign awready = !aw_full && !bvalid;
   assign wready  = !w_full  && !bvalid;
   assign arready = !rvalid;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid  && wready;
   assign ar_hs = arvalid && arready;
   assign b_hs  = bvalid  && bready;
   assign r_hs  = rvalid  && rready;

   // Commit once both halves of the write are held; the !bvalid term keeps a
   // second commit from overwriting an unacknowledged response.
   assign commit     = aw_full && w_full && !bvalid;
   assign commit_ok  = addr_ok(aw_addr);
   assign commit_idx = reg_index(aw_addr);

   // -------------------------------------------------------------------------
   // AW / W holding registers
   // -------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_full <= 1'b0;
         aw_addr <= '0;
         w_full  <= 1'b0;
         w_data  <= '0;
         w_strb  <= '0;
      end else if (commit) begin
         // Neither ready is high while both flags are set, so no capture can
         // coincide with the commit.
         aw_full <= 1'b0;
         w_full  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_addr <= awaddr;
         end
         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Write response channel and commit pulse
   // -------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bvalid   <= 1'b0;
         bresp    <= RESP_OKAY;
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         if (commit) begin
            bvalid <= 1'b1;
            bresp  <= commit_ok ? RESP_OKAY : RESP_SLVERR;
            // Pulses even for an all-zero strobe: the write was still committed.
            if (commit_ok) begin
               wr_pulse[commit_idx] <= 1'b1;
            end
         end else if (b_hs) begin
            bvalid <= 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Register bank
   // -------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (commit && commit_ok) begin
         regs[commit_idx] <= merge_bytes(regs[commit_idx], w_data, w_strb);
      end
   end

   // -------------------------------------------------------------------------
   // Read channel. The bank is sampled with its pre-edge contents, so a read
   // accepted on the same edge as a commit returns the old value.
   // -------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         if (addr_ok(araddr)) begin
            rdata <= regs[reg_index(araddr)];
            rresp <= RESP_OKAY;
         end else begin
            rdata <= '0;
            rresp <= RESP_SLVERR;
         end
      end else if (r_hs) begin
         // rdata/rresp keep their last values; only the valid drops.
         rvalid <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Flattened register view for local hardware
   // -------------------------------------------------------------------------
   for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg_q
      assign reg_q[g*DW +: DW] = regs[g];
   end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_reg_slave
//
// Bench for axi4_lite_reg_slave with default parameters. A transaction-level
// model tracks accepted addresses/data by cycle number and predicts every
// output on each falling clock edge; directed sequences pin literal values,
// followed by randomized concurrent write and read traffic with random
// bready/rready back-pressure.
// ---------------------------------------------------------------------------
module tb_axi4_lite_reg_slave;

   localparam int A  = 12;
   localparam int N  = 4;
   localparam int RC = 8;
   localparam int DW = 8 * N;

   logic              aclk    = 1'b0;
   logic              aresetn = 1'b0;
   logic [A-1:0]      awaddr  = '0;
   logic              awvalid = 1'b0;
   logic              awready;
   logic [DW-1:0]     wdata   = '0;
   logic [N-1:0]      wstrb   = '0;
   logic              wvalid  = 1'b0;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready  = 1'b1;
   logic [A-1:0]      araddr  = '0;
   logic              arvalid = 1'b0;
   logic              arready;
   logic [DW-1:0]     rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready  = 1'b1;
   logic [RC*DW-1:0]  reg_q;
   logic [RC-1:0]     wr_pulse;

   always #5 aclk = ~aclk;

   axi4_lite_reg_slave #(
      .A         (A),
      .N         (N),
      .REG_COUNT (RC),
      .USE_STRB  (1'b1)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .awaddr   (awaddr),
      .awvalid  (awvalid),
      .awready  (awready),
      .wdata    (wdata),
      .wstrb    (wstrb),
      .wvalid   (wvalid),
      .wready   (wready),
      .bresp    (bresp),
      .bvalid   (bvalid),
      .bready   (bready),
      .araddr   (araddr),
      .arvalid  (arvalid),
      .arready  (arready),
      .rdata    (rdata),
      .rresp    (rresp),
      .rvalid   (rvalid),
      .rready   (rready),
      .reg_q    (reg_q),
      .wr_pulse (wr_pulse)
   );

   int total  = 0;
   int passed = 0;
   int cyc    = 0;
   bit rand_on = 1'b0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end else begin
         passed++;
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: registers as an array, writes tracked by the cycle
   // in which each half was accepted; commit becomes visible two cycles
   // after the later of the two acceptances.
   // ---------------------------------------------------------------------
   logic [DW-1:0] m_regs [RC];
   bit            aw_taken, w_taken, wr_sched;
   int            aw_t, w_t, wr_cycle;
   logic [A-1:0]  m_awaddr;
   logic [DW-1:0] m_wdata;
   logic [N-1:0]  m_wstrb;
   bit            m_bvalid, m_rvalid;
   logic [1:0]    m_bresp, m_rresp;
   logic [DW-1:0] m_rdata;
   logic [RC-1:0] m_pulse;

   function automatic bit in_rng(input logic [A-1:0] a);
      return int'(a) < RC * N;
   endfunction

   function automatic int reg_of(input logic [A-1:0] a);
      return (int'(a) / N) % RC;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < RC; i++) m_regs[i] = '0;
      aw_taken = 0; w_taken = 0; wr_sched = 0;
      m_bvalid = 0; m_rvalid = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_pulse = '0;
   endtask

   task automatic compare_all();
      logic [RC*DW-1:0] exp_q;
      for (int i = 0; i < RC; i++) exp_q[i*DW +: DW] = m_regs[i];
      chk("reg_q",    reg_q,    exp_q);
      chk("wr_pulse", wr_pulse, m_pulse);
      chk("awready",  awready,  !aw_taken);
      chk("wready",   wready,   !w_taken);
      chk("arready",  arready,  !m_rvalid);
      chk("bvalid",   bvalid,   m_bvalid);
      chk("rvalid",   rvalid,   m_rvalid);
      if (m_bvalid) chk("bresp", bresp, m_bresp);
      if (m_rvalid) begin
         chk("rdata", rdata, m_rdata);
         chk("rresp", rresp, m_rresp);
      end
   endtask

   always @(negedge aclk) begin
      cyc++;
      if (!aresetn) begin
         model_reset();
         compare_all();
         chk("bresp_rst", bresp, 2'b00);
         chk("rresp_rst", rresp, 2'b00);
         chk("rdata_rst", rdata, 32'h0);
      end else begin
         m_pulse = '0;
         if (wr_sched && cyc == wr_cycle) begin
            if (in_rng(m_awaddr)) begin
               for (int k = 0; k < N; k++)
                  if (m_wstrb[k]) m_regs[reg_of(m_awaddr)][8*k +: 8] = m_wdata[8*k +: 8];
               m_pulse[reg_of(m_awaddr)] = 1'b1;
               m_bresp = 2'b00;
            end else begin
               m_bresp = 2'b10;
            end
            m_bvalid = 1;
            wr_sched = 0;
         end
         compare_all();
         // write side: one outstanding write until its B handshake
         if (m_bvalid && bready) begin
            m_bvalid = 0; aw_taken = 0; w_taken = 0;
         end else begin
            if (awvalid && !aw_taken) begin
               aw_taken = 1; aw_t = cyc; m_awaddr = awaddr;
            end
            if (wvalid && !w_taken) begin
               w_taken = 1; w_t = cyc; m_wdata = wdata; m_wstrb = wstrb;
            end
            if (aw_taken && w_taken && !wr_sched && !m_bvalid) begin
               wr_sched = 1;
               wr_cycle = ((aw_t > w_t) ? aw_t : w_t) + 2;
            end
         end
         // read side: value as seen in this cycle
         if (m_rvalid) begin
            if (rready) m_rvalid = 0;
         end else if (arvalid) begin
            m_rvalid = 1;
            m_rdata  = in_rng(araddr) ? m_regs[reg_of(araddr)] : '0;
            m_rresp  = in_rng(araddr) ? 2'b00 : 2'b10;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Channel drivers (called just after a rising edge)
   // ---------------------------------------------------------------------
   task automatic send_aw(input logic [A-1:0] a);
      bit got = 0;
      awaddr = a; awvalid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge aclk);
         if (awready) begin got = 1; break; end
      end
      if (!got) chk("aw_accept_timeout", awready, 1'b1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [N-1:0] s);
      bit got = 0;
      wdata = d; wstrb = s; wvalid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge aclk);
         if (wready) begin got = 1; break; end
      end
      if (!got) chk("w_accept_timeout", wready, 1'b1);
      @(posedge aclk); #1;
      wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [A-1:0] a);
      bit got = 0;
      araddr = a; arvalid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge aclk);
         if (arready) begin got = 1; break; end
      end
      if (!got) chk("ar_accept_timeout", arready, 1'b1);
      @(posedge aclk); #1;
      arvalid = 1'b0;
   endtask

   // Returns at the falling edge of the first cycle with bvalid high.
   task automatic wait_b();
      bit got = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge aclk);
         if (bvalid) begin got = 1; break; end
      end
      if (!got) chk("bvalid_timeout", bvalid, 1'b1);
   endtask

   task automatic wait_b_hs();
      bit got = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge aclk);
         if (bvalid && bready) begin got = 1; break; end
      end
      if (!got) chk("b_handshake_timeout", bvalid, 1'b1);
      @(posedge aclk); #1;
   endtask

   task automatic wait_r_hs();
      bit got = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge aclk);
         if (rvalid && rready) begin got = 1; break; end
      end
      if (!got) chk("r_handshake_timeout", rvalid, 1'b1);
      @(posedge aclk); #1;
   endtask

   function automatic logic [A-1:0] rand_addr();
      logic [A-1:0] a;
      a = A'($urandom_range(0, RC - 1) * N + $urandom_range(0, N - 1));
      if ($urandom_range(0, 7) == 0) a = a + A'($urandom_range(1, 127) * RC * N);
      return a;
   endfunction

   task automatic write_proc();
      for (int n = 0; n < 60; n++) begin
         logic [A-1:0]  a;
         logic [DW-1:0] d;
         logic [N-1:0]  s;
         int            d1, d2;
         a  = rand_addr();
         d  = $urandom();
         s  = N'($urandom_range(0, 15));
         d1 = $urandom_range(0, 3);
         d2 = $urandom_range(0, 3);
         fork
            begin
               if (d1 > 0) begin repeat (d1) @(posedge aclk); #1; end
               send_aw(a);
            end
            begin
               if (d2 > 0) begin repeat (d2) @(posedge aclk); #1; end
               send_w(d, s);
            end
         join
         wait_b_hs();
      end
   endtask

   task automatic read_proc();
      for (int n = 0; n < 80; n++) begin
         int dl;
         dl = $urandom_range(0, 2);
         if (dl > 0) begin repeat (dl) @(posedge aclk); #1; end
         send_ar(rand_addr());
         wait_r_hs();
      end
   endtask

   task automatic ready_proc();
      while (rand_on) begin
         @(posedge aclk); #1;
         bready = ($urandom_range(0, 3) != 0);
         rready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // ---------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------
   initial begin
      repeat (3) @(posedge aclk);
      #3 aresetn = 1'b1;
      @(posedge aclk); #1;

      // AW + W together: response two cycles after acceptance
      fork
         send_aw(12'h004);
         send_w(32'hDEADBEEF, 4'hF);
      join
      @(negedge aclk);
      chk("t1_bvalid_early", bvalid, 1'b0);
      @(negedge aclk);
      chk("t1_bvalid",   bvalid, 1'b1);
      chk("t1_bresp",    bresp, 2'b00);
      chk("t1_reg1",     reg_q[63:32], 32'hDEADBEEF);
      chk("t1_wr_pulse", wr_pulse, 8'h02);
      @(posedge aclk); #1;

      // W three cycles ahead of AW, partial strobe
      send_w(32'h11223344, 4'b0101);
      repeat (2) @(posedge aclk); #1;
      send_aw(12'h008);
      wait_b();
      chk("t2_reg2",  reg_q[95:64], 32'h00220044);
      chk("t2_bresp", bresp, 2'b00);
      @(posedge aclk); #1;

      // out-of-range write and read
      fork
         send_aw(12'h400);
         send_w(32'hFFFFFFFF, 4'hF);
      join
      wait_b();
      chk("t3_bresp",    bresp, 2'b10);
      chk("t3_reg_q",    reg_q, 256'h00220044_DEADBEEF_00000000);
      chk("t3_wr_pulse", wr_pulse, 8'h00);
      @(posedge aclk); #1;
      send_ar(12'h400);
      @(negedge aclk);
      chk("t3_rvalid", rvalid, 1'b1);
      chk("t3_rresp",  rresp, 2'b10);
      chk("t3_rdata",  rdata, 32'h0);
      @(posedge aclk); #1;

      // B back-pressure: response holds, no new AW/W accepted
      bready = 1'b0;
      fork
         send_aw(12'h00C);
         send_w(32'h0BADF00D, 4'hF);
      join
      wait_b();
      @(posedge aclk); #1;
      awaddr = 12'h010; awvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         chk("t4_bvalid_hold",  bvalid, 1'b1);
         chk("t4_bresp_hold",   bresp, 2'b00);
         chk("t4_awready_hold", awready, 1'b0);
         chk("t4_wready_hold",  wready, 1'b0);
      end
      @(posedge aclk); #1;
      bready = 1'b1;
      @(negedge aclk);
      chk("t4_awready_at_b", awready, 1'b0);
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("t4_awready_after_b", awready, 1'b1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      send_w(32'hCAFEF00D, 4'hF);
      wait_b();
      chk("t4_reg4", reg_q[159:128], 32'hCAFEF00D);
      chk("t4_reg3", reg_q[127:96],  32'h0BADF00D);
      @(posedge aclk); #1;

      // read accepted on the commit edge returns the old value
      fork
         send_aw(12'h004);
         send_w(32'h5A5A5A5A, 4'hF);
      join
      araddr = 12'h004; arvalid = 1'b1;
      @(posedge aclk); #1;
      arvalid = 1'b0;
      @(negedge aclk);
      chk("t5_rvalid",    rvalid, 1'b1);
      chk("t5_rdata_old", rdata, 32'hDEADBEEF);
      chk("t5_bvalid",    bvalid, 1'b1);
      chk("t5_reg1_new",  reg_q[63:32], 32'h5A5A5A5A);
      @(posedge aclk); #1;
      send_ar(12'h004);
      @(negedge aclk);
      chk("t5_rdata_new", rdata, 32'h5A5A5A5A);
      @(posedge aclk); #1;

      // reset while both responses are pending
      bready = 1'b0; rready = 1'b0;
      fork
         send_aw(12'h01C);
         send_w(32'h12345678, 4'hF);
         send_ar(12'h008);
      join
      wait_b();
      chk("t6_rvalid_pre", rvalid, 1'b1);
      @(posedge aclk); #3;
      aresetn = 1'b0;
      #1;
      chk("t6_bvalid_rst",   bvalid, 1'b0);
      chk("t6_rvalid_rst",   rvalid, 1'b0);
      chk("t6_reg_q_rst",    reg_q, 256'h0);
      chk("t6_wr_pulse_rst", wr_pulse, 8'h00);
      repeat (2) @(posedge aclk); #3;
      aresetn = 1'b1;
      @(negedge aclk);
      chk("t6_awready", awready, 1'b1);
      chk("t6_wready",  wready,  1'b1);
      chk("t6_arready", arready, 1'b1);
      @(posedge aclk); #1;
      bready = 1'b1; rready = 1'b1;
      repeat (3) @(posedge aclk); #1;

      // randomized concurrent traffic with back-pressure
      rand_on = 1'b1;
      fork
         begin
            fork
               write_proc();
               read_proc();
            join
            rand_on = 1'b0;
         end
         ready_proc();
      join
      bready = 1'b1; rready = 1'b1;
      repeat (5) @(posedge aclk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
      $fatal(1);
   end

endmodule
